vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, next generation of the lab VGA controller. Resolution, porch/sync widths, sync polarity, clock divide ratio and horizontal zone count are configurable. Produces the sync, blanking, pixel clock and coordinate/zone signals that feed the pixel-colour logic and the 7-segment status path. Adds run/pause control, frame/line strobes and a frame counter.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_pixel_ce.sv | 44 ++++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing description and elaboration-time helpers for the raster
// timing generator.
package vga_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
  };

  function automatic int h_total(input vga_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

  // First pixel column of zone k; thresholds are constants, so no divider is built.
  function automatic int zone_lo(input int k, input int h_active, input int zones);
    return (k * h_active) / zones;
  endfunction

endpackage

// File: rtl/vga_pixel_ce.sv
// Pixel-rate divider: produces the per-pixel advance, the registered pix_ce
// strobe and the DAC pixel clock.
module vga_pixel_ce #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic advance,
  output logic pix_ce,
  output logic clock_vga
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  assign advance = enable && (div == DIV_LAST);

  always_comb begin
    div_next = div;
    if (advance)
      div_next = '0;
    else if (enable)
      div_next = div + 1'b1;
  end

  // Outputs decode the next divider value so they line up with the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      pix_ce    <= 1'b0;
      clock_vga <= 1'b0;
    end else begin
      div       <= div_next;
      pix_ce    <= enable && (div_next == DIV_LAST);
      clock_vga <= (div_next >= DIV_HALF);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, sync/blank/zone
// decode, line/frame strobes and a completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = int'(VGA_640x480.h_active),
  parameter int H_FP     = int'(VGA_640x480.h_fp),
  parameter int H_SYNC   = int'(VGA_640x480.h_sync),
  parameter int H_BP     = int'(VGA_640x480.h_bp),
  parameter int V_ACTIVE = int'(VGA_640x480.v_active),
  parameter int V_FP     = int'(VGA_640x480.v_fp),
  parameter int V_SYNC   = int'(VGA_640x480.v_sync),
  parameter int V_BP     = int'(VGA_640x480.v_bp),
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int ZONES    = 4,
  localparam vga_timing_t TIMING = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
  },
  localparam int H_TOTAL = h_total(TIMING),
  localparam int V_TOTAL = v_total(TIMING),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL),
  localparam int ZW      = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic          clockVGA,
  output logic          pix_ce,
  output logic [HW-1:0] pix_x,
  output logic [VW-1:0] pix_y,
  output logic [ZW-1:0] zone,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  logic          advance;
  logic          h_wrap;
  logic          v_wrap;
  logic [HW-1:0] h_cnt;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_next;
  logic          h_act;
  logic          v_act;
  logic          hs_on;
  logic          vs_on;
  logic [ZW-1:0] zone_next;
  logic [15:0]   frame_cnt;

  vga_pixel_ce #(.CLK_DIV(CLK_DIV)) u_pixel_ce (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .advance   (advance),
    .pix_ce    (pix_ce),
    .clock_vga (clockVGA)
  );

  assign h_wrap = advance && (h_cnt == HW'(H_TOTAL - 1));
  assign v_wrap = h_wrap && (v_cnt == VW'(V_TOTAL - 1));

  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (advance)
      h_next = h_wrap ? '0 : h_cnt + 1'b1;
    if (h_wrap)
      v_next = v_wrap ? '0 : v_cnt + 1'b1;
  end

  assign h_act = (h_next < HW'(H_ACTIVE));
  assign v_act = (v_next < VW'(V_ACTIVE));
  assign hs_on = (h_next >= HW'(H_ACTIVE + H_FP)) && (h_next < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on = (v_next >= VW'(V_ACTIVE + V_FP)) && (v_next < VW'(V_ACTIVE + V_FP + V_SYNC));

  // Thresholds ascend with k, so the last one passed names the zone.
  always_comb begin
    zone_next = '0;
    for (int k = 1; k < ZONES; k++)
      if (h_next >= HW'(zone_lo(k, H_ACTIVE, ZONES)))
        zone_next = ZW'(k);
    if (!(h_act && v_act))
      zone_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      vga_hs      <= !HS_POL;
      vga_vs      <= !VS_POL;
      vga_blank_n <= 1'b0;
      zone        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      vga_hs      <= hs_on ? HS_POL : !HS_POL;
      vga_vs      <= vs_on ? VS_POL : !VS_POL;
      vga_blank_n <= h_act && v_act;
      zone        <= zone_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (v_wrap)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance and a small
// non-default instance (CLK_DIV=4, active-high hsync, 3 zones, short frame).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset1, enable1, reset2, enable2;

  logic        hs1, vs1, blank1, cvga1, pce1, ls1, fs1;
  logic [9:0]  x1, y1;
  logic [1:0]  zone1;
  logic [15:0] fc1;

  logic        hs2, vs2, blank2, cvga2, pce2, ls2, fs2;
  logic [8:0]  x2;
  logic [2:0]  y2;
  logic [1:0]  zone2;
  logic [15:0] fc2;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut1 (
    .clk(clk), .reset(reset1), .enable(enable1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_blank_n(blank1), .clockVGA(cvga1),
    .pix_ce(pce1), .pix_x(x1), .pix_y(y1), .zone(zone1),
    .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  vga_timing_gen #(
    .H_ACTIVE(320), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .CLK_DIV(4), .ZONES(3)
  ) dut2 (
    .clk(clk), .reset(reset2), .enable(enable2),
    .vga_hs(hs2), .vga_vs(vs2), .vga_blank_n(blank2), .clockVGA(cvga2),
    .pix_ce(pce2), .pix_x(x2), .pix_y(y2), .zone(zone2),
    .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r1, input logic e1, input logic r2, input logic e2);
    reset1  = r1;
    enable1 = e1;
    reset2  = r2;
    enable2 = e2;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  int zx1[6] = '{0, 160, 320, 480, 639, 640};
  int zz1[6] = '{0, 1, 2, 3, 3, 0};
  int zx2[6] = '{105, 106, 212, 213, 319, 320};
  int zz2[6] = '{0, 1, 1, 2, 2, 0};

  initial begin
    int pceCnt, hsLow, hsFirstX, lsCnt, hsHigh, vsLow, fsCnt;
    bit found;

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (5) stepClock();
    checkOutput("rst_hs", hs1, 1);
    checkOutput("rst_vs", vs1, 1);
    checkOutput("rst_blank", blank1, 0);
    checkOutput("rst_x", x1, 0);
    checkOutput("rst_pce", pce1, 0);
    checkOutput("rst_cvga", cvga1, 0);
    checkOutput("rst_fc", fc1, 0);
    checkOutput("rst_hs_pol1", hs2, 0);

    // One full default line from reset release.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    pceCnt = 0; hsLow = 0; hsFirstX = -1; lsCnt = 0;
    for (int n = 1; n <= 1600; n++) begin
      stepClock();
      if (n == 1) begin
        checkOutput("blank_after_release", blank1, 1);
        checkOutput("first_pix_ce", pce1, 1);
        checkOutput("x_after_release", x1, 0);
        checkOutput("cvga_after_release", cvga1, 1);
      end
      if (n == 2) begin
        checkOutput("x_second_pixel", x1, 1);
        checkOutput("pce_second", pce1, 0);
      end
      if (pce1) pceCnt++;
      if (!hs1) begin
        if (hsLow == 0) hsFirstX = int'(x1);
        hsLow++;
      end
      if (ls1) lsCnt++;
      if (pce1 && y1 == 0)
        for (int i = 0; i < 6; i++)
          if (int'(x1) == zx1[i]) checkOutput($sformatf("zone_x%0d", zx1[i]), zone1, zz1[i]);
    end
    checkOutput("pce_per_line", pceCnt, 800);
    checkOutput("hs_low_clk", hsLow, 192);
    checkOutput("hs_first_x", hsFirstX, 656);
    checkOutput("line_start_count", lsCnt, 1);
    checkOutput("line_end_ls", ls1, 1);
    checkOutput("line_end_x", x1, 0);
    checkOutput("line_end_y", y1, 1);
    checkOutput("line_end_fs", fs1, 0);
    checkOutput("line_end_vs", vs1, 1);

    // Freeze at pix_x=300 for 37 clk.
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      stepClock();
      if (x1 == 10'd300) found = 1'b1;
    end
    checkOutput("wait_x300", found, 1);
    checkOutput("x300_cvga", cvga1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 37; n++) begin
      stepClock();
      checkOutput("freeze_x", x1, 300);
      checkOutput("freeze_cvga", cvga1, 0);
      checkOutput("freeze_fc", fc1, 0);
    end
    checkOutput("freeze_pce", pce1, 0);
    checkOutput("freeze_blank", blank1, 1);
    checkOutput("freeze_ls", ls1, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    stepClock();
    checkOutput("resume_x0", x1, 300);
    checkOutput("resume_pce", pce1, 1);
    stepClock();
    checkOutput("resume_x1", x1, 301);
    stepClock();
    stepClock();
    checkOutput("resume_x2", x1, 302);

    // Reset mid-frame while frozen.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    stepClock();
    checkOutput("midrst_x", x1, 0);
    checkOutput("midrst_y", y1, 0);
    checkOutput("midrst_blank", blank1, 0);
    checkOutput("midrst_hs", hs1, 1);
    checkOutput("midrst_ls", ls1, 0);
    checkOutput("midrst_fs", fs1, 0);

    // Non-default instance: two full frames (480 x 8 pixels, 4 clk each).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    hsHigh = 0; vsLow = 0; fsCnt = 0;
    for (int n = 1; n <= 30720; n++) begin
      stepClock();
      if (n <= 8) checkOutput($sformatf("cvga2_n%0d", n), cvga2, ((n % 4) >= 2) ? 1 : 0);
      if (n <= 1920 && hs2) hsHigh++;
      if (n <= 15360 && !vs2) vsLow++;
      if (fs2) fsCnt++;
      if (pce2 && y2 == 0)
        for (int i = 0; i < 6; i++)
          if (int'(x2) == zx2[i]) checkOutput($sformatf("zone2_x%0d", zx2[i]), zone2, zz2[i]);
      if (n == 1920) begin
        checkOutput("d2_line_ls", ls2, 1);
        checkOutput("d2_line_fs", fs2, 0);
        checkOutput("d2_line_y", y2, 1);
      end
      if (n == 15360) begin
        checkOutput("d2_frame1_fs", fs2, 1);
        checkOutput("d2_frame1_ls", ls2, 1);
        checkOutput("d2_frame1_fc", fc2, 1);
        checkOutput("d2_frame1_x", x2, 0);
        checkOutput("d2_frame1_y", y2, 0);
      end
      if (n == 30720) begin
        checkOutput("d2_frame2_fs", fs2, 1);
        checkOutput("d2_frame2_fc", fc2, 2);
      end
    end
    checkOutput("d2_hs_high_clk", hsHigh, 384);
    checkOutput("d2_vs_low_clk", vsLow, 3840);
    checkOutput("d2_fs_count", fsCnt, 2);

    // Preload the frame counter just below wrap, then finish one more frame.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    force dut2.frame_cnt = 16'hFFFF;
    stepClock();
    release dut2.frame_cnt;
    stepClock();
    checkOutput("d2_fc_preload", fc2, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 16000 && !found; n++) begin
      stepClock();
      if (fs2) found = 1'b1;
    end
    checkOutput("d2_wait_wrap", found, 1);
    checkOutput("d2_fc_wrap", fc2, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
